wrr_arbiter: RTL and testbench
==============================

// Module: wrr_arbiter
//
// PURPOSE
// - Weighted round-robin arbiter. Successor to the single-cycle rr_arbiter.
// - Each client gets a burst of up to weight[i] consecutive grant cycles while it keeps requesting.
// - Rotation is fair, and both grant and burst state freeze under stall.
// - Sits in front of shared resources (bus ports, memory banks) whose clients need unequal bandwidth.
//
// PARAMETERS
// - CLIENTS   32  number of requesters, >= 2
// - WEIGHT_W  4   bits per client weight; burst length is 1 .. 2**WEIGHT_W-1
//
// PORTS
// - clock        in   1                  clock, all state updates on posedge
// - reset        in   1                  synchronous, active-high
// - request      in   CLIENTS            per-client request level
// - stall        in   1                  freeze arbitration state and grant
// - weight       in   CLIENTS*WEIGHT_W   client i weight at [i*WEIGHT_W +: WEIGHT_W], quasi-static
// - grant        out  CLIENTS            registered, one-hot or zero
// - grant_valid  out  1                  |grant, registered
// - grant_id     out  $clog2(CLIENTS)    index of granted client; 0 when grant_valid=0
//
// BEHAVIOUR
// - Clocking and reset
//   - reset and clock are as listed in PORTS: synchronous, active-high reset on clock.
//   - Reset values: grant=0, grant_valid=0, grant_id=0, ptr=0, credit=0, owner invalid.
//   - Reset overrides stall. Reset mid-burst gives grant=0 on the next cycle; the burst is discarded.
// - Latency: registered, 1 cycle.
//   - Request rising at edge n, with the arbiter free: grant at edge n+1.
// - State
//   - ptr: search start index.
//   - owner: current grantee.
//   - credit: remaining burst cycles, WEIGHT_W bits.
// - Each non-stalled cycle is one of two cases:
//   - HOLD: owner valid, request[owner]=1 and credit>1.
//     - Grant unchanged, credit-=1.
//   - ARB: any other case.
//     - Pick the first requester at or after ptr, going upward with wrap CLIENTS-1 -> 0.
//     - On a pick: grant it, load credit=eff_weight(weight[idx]), set ptr=(idx+1) mod CLIENTS.
//     - No requester: grant=0, owner invalid, ptr unchanged.
// - eff_weight(w) = (w==0) ? 1 : w. Weight 0 never starves a client.
// - Weight is sampled only when the credit loads. Changes mid-burst apply at the next load.
// - Owner dropping request mid-burst: the burst ends. The same cycle re-arbitrates from ptr, so there is no idle cycle when others request.
// - Burst exhausted while the owner still requests: the owner goes to the back of rotation.
//   - It is re-granted immediately only if it is the sole requester; then it reloads its credit.
// - stall=1: grant, grant_id, grant_valid, ptr, credit and owner all hold.
//   - stall cycles do not consume credit.
// - Fairness: a continuously requesting client is granted within sum over j!=i of eff_weight[j] non-stalled cycles.
//   - For CLIENTS=32, WEIGHT_W=4 the bound is <= 31*15 = 465.
// - Invariants
//   - $onehot0(grant).
//   - grant_valid == |grant.
//   - grant implies request held the previous cycle, or stall.
//   - credit != 0 whenever grant_valid.
//
// STRUCTURE
// - wrr_arbiter_pkg holds:
//   - localparam ID_W = $clog2(CLIENTS), via a parameterised helper.
//   - function eff_weight.
//   - function onehot_to_idx.
// - Sub-module wrr_pick: combinational rotating priority encoder.
//   - Inputs: request, ptr.
//   - Outputs: found, idx.
//   - Implemented by double-width request vector, rotate, find-first.
// - The top level holds the HOLD/ARB decision, the credit counter, ptr/owner registers and the output registers.
//
// TESTING
// - Reset
//   - Stimulus: hold reset 3 cycles with request='1.
//   - Required: grant=0, grant_valid=0, grant_id=0 throughout; first grant is client 0 one cycle after reset falls.
// - Plain round robin
//   - Stimulus: all weights 1, request='1.
//   - Required: grant_id 0,1,2,...,31,0 on consecutive cycles.
// - Weighted pair
//   - Stimulus: w[4]=3, w[5]=1, request=bits 4 and 5 held.
//   - Required: grant_id 4,4,4,5,4,4,4,5,...
// - Zero weight
//   - Stimulus: w[2]=0, request=bits 2 and 3.
//   - Required: alternating 2,3,2,3 (weight 0 behaves as 1).
// - Stall
//   - Stimulus: w[4]=3, client 4 granted one cycle, then stall=1 for 5 cycles.
//   - Required: grant[4] held through the stall, then exactly 2 more grant[4] cycles.
// - Early release and reset mid-burst
//   - Stimulus: w[7]=8, client 7 drops request after 2 grant cycles while client 9 requests.
//   - Required: next cycle grant_id=9.
//   - Also: reset in cycle 3 of a burst gives grant=0 next cycle.
// - Formal
//   - request[4] held |-> ##[1:466] grant[4] with stall tied low.
//   - Plus the invariants above as concurrent assertions.

Source files
------------

// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Covers width selection, weight normalisation and one-hot decoding.
package wrr_arbiter_pkg;

  // Widest request vector the one-hot decoder accepts.
  localparam int MAX_CLIENTS = 256;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } mode_e;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W = id_width(32);

  // A zero weight still earns one grant cycle, so no client can be starved.
  function automatic int eff_weight(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_CLIENTS-1:0] v);
    int idx = 0;
    for (int i = 0; i < MAX_CLIENTS; i++)
      if (v[i]) idx = idx | i;
    return idx;
  endfunction

endpackage

// File: rtl/wrr_arbiter_pick.sv
// Combinational rotating priority encoder.
// Returns the first requester at or after ptr, wrapping from CLIENTS-1 to 0.
module wrr_pick
  import wrr_arbiter_pkg::*;
#(
  parameter  int CLIENTS = 32,
  localparam int SEL_W   = id_width(CLIENTS)
) (
  input  logic [CLIENTS-1:0] request,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [2*CLIENTS-1:0] dbl;
  logic [2*CLIENTS-1:0] rot;
  logic [CLIENTS-1:0]   low;
  logic [CLIENTS-1:0]   first;
  int                   off;
  int                   sum;

  // The doubled vector lets a plain right shift act as a rotation.
  always_comb begin
    dbl   = {request, request};
    rot   = dbl >> ptr;
    low   = rot[CLIENTS-1:0];
    first = low & (~low + CLIENTS'(1));
    found = |low;
    off   = onehot_to_idx(MAX_CLIENTS'(first));
    sum   = off + int'(ptr);
    if (sum >= CLIENTS) sum = sum - CLIENTS;
    idx   = SEL_W'(sum);
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each grantee keeps the grant for up to
// eff_weight(weight[i]) consecutive cycles while it keeps requesting.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter  int CLIENTS  = 32,
  parameter  int WEIGHT_W = 4,
  localparam int SEL_W    = id_width(CLIENTS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CLIENTS-1:0]          request,
  input  logic                        stall,
  input  logic [CLIENTS*WEIGHT_W-1:0] weight,
  output logic [CLIENTS-1:0]          grant,
  output logic                        grant_valid,
  output logic [SEL_W-1:0]            grant_id
);

  logic [SEL_W-1:0]    ptr;
  logic [WEIGHT_W-1:0] credit;
  logic                found;
  logic [SEL_W-1:0]    idx;
  mode_e               mode;

  wrr_pick #(.CLIENTS(CLIENTS)) u_pick (
    .request (request),
    .ptr     (ptr),
    .found   (found),
    .idx     (idx)
  );

  // The owner is grant_id while grant_valid; no separate owner register needed.
  always_comb begin
    mode = ARB;
    if (grant_valid && request[grant_id] && credit > WEIGHT_W'(1)) mode = HOLD;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      ptr         <= '0;
      credit      <= '0;
    end else if (!stall) begin
      if (mode == HOLD) begin
        credit <= credit - WEIGHT_W'(1);
      end else if (found) begin
        grant       <= CLIENTS'(1) << idx;
        grant_valid <= 1'b1;
        grant_id    <= idx;
        credit      <= WEIGHT_W'(eff_weight(int'(weight[int'(idx)*WEIGHT_W +: WEIGHT_W])));
        ptr         <= (idx == SEL_W'(CLIENTS-1)) ? '0 : idx + SEL_W'(1);
      end else begin
        grant       <= '0;
        grant_valid <= 1'b0;
        grant_id    <= '0;
        credit      <= '0;
      end
    end
  end

  a_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(grant));
  a_valid:  assert property (@(posedge clock) disable iff (reset) grant_valid == |grant);
  a_credit: assert property (@(posedge clock) disable iff (reset) grant_valid |-> credit != '0);
  a_cause:  assert property (@(posedge clock) disable iff (reset)
              (grant_valid && !$past(reset)) |-> ($past(stall) || |($past(request) & grant)));

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: expected grants are queued when stimulus is
// applied and compared after each clock edge.
module tb_wrr_arbiter;

  localparam int CLIENTS  = 32;
  localparam int WEIGHT_W = 4;

  typedef struct packed {
    logic       vld;
    logic [4:0] id;
  } exp_t;

  logic                        clock;
  logic                        reset;
  logic [CLIENTS-1:0]          request;
  logic                        stall;
  logic [CLIENTS*WEIGHT_W-1:0] weight;
  logic [CLIENTS-1:0]          grant;
  logic                        grant_valid;
  logic [4:0]                  grant_id;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  wrr_arbiter #(.CLIENTS(CLIENTS), .WEIGHT_W(WEIGHT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .request     (request),
    .stall       (stall),
    .weight      (weight),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic expect_grant(input logic v, input int id);
    exp_t e;
    e.vld = v;
    e.id  = 5'(id);
    exp_q.push_back(e);
  endtask

  // One clock edge, then compare the oldest expectation against the outputs.
  task automatic tick(input string tag);
    exp_t        e;
    logic [37:0] obs;
    logic [37:0] want;
    logic [31:0] one_hot;
    @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, got id=%0d v=%b", tag, grant_id, grant_valid);
    end else begin
      e       = exp_q.pop_front();
      one_hot = e.vld ? (32'd1 << e.id) : 32'd0;
      want    = {one_hot, e.vld, e.id};
      obs     = {grant, grant_valid, grant_id};
      assert (obs === want) else begin
        errors++;
        $error("FAIL %s: got grant=%h v=%b id=%0d, want grant=%h v=%b id=%0d",
               tag, grant, grant_valid, grant_id, one_hot, e.vld, e.id);
      end
    end
  endtask

  task automatic step(input logic v, input int id, input string tag);
    expect_grant(v, id);
    tick(tag);
  endtask

  task automatic set_w(input int i, input int w);
    weight[i*WEIGHT_W +: WEIGHT_W] = 4'(w);
  endtask

  task automatic default_weights();
    for (int i = 0; i < CLIENTS; i++) set_w(i, 1);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    request = '0;
    stall   = 1'b0;
    step(1'b0, 0, "reset_pulse");
    reset   = 1'b0;
    default_weights();
  endtask

  initial begin
    reset   = 1'b1;
    stall   = 1'b0;
    request = '1;
    weight  = '0;
    default_weights();

    // Reset held three cycles with everyone requesting.
    for (int i = 0; i < 3; i++) step(1'b0, 0, "reset_hold");
    reset = 1'b0;
    step(1'b1, 0, "first_grant");

    // Plain round robin with unit weights.
    for (int i = 1; i <= CLIENTS; i++) step(1'b1, i % CLIENTS, "plain_rr");

    // Weighted pair 4:3, 5:1.
    do_reset();
    set_w(4, 3);
    set_w(5, 1);
    request = 32'h0000_0030;
    for (int r = 0; r < 2; r++) begin
      step(1'b1, 4, "wpair_4a");
      step(1'b1, 4, "wpair_4b");
      step(1'b1, 4, "wpair_4c");
      step(1'b1, 5, "wpair_5");
    end

    // Weight zero behaves as one.
    do_reset();
    set_w(2, 0);
    request = 32'h0000_000C;
    for (int r = 0; r < 3; r++) begin
      step(1'b1, 2, "zero_w_2");
      step(1'b1, 3, "zero_w_3");
    end

    // Stall freezes grant and credit; burst resumes with two cycles left.
    do_reset();
    set_w(4, 3);
    request = 32'h0000_0050;
    step(1'b1, 4, "stall_pre");
    stall = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 4, "stall_hold");
    stall = 1'b0;
    step(1'b1, 4, "stall_rest1");
    step(1'b1, 4, "stall_rest2");
    step(1'b1, 6, "stall_next");

    // Early release hands over in the same cycle.
    do_reset();
    set_w(7, 8);
    request = 32'h0000_0280;
    step(1'b1, 7, "early_7a");
    step(1'b1, 7, "early_7b");
    request = 32'h0000_0200;
    step(1'b1, 9, "early_9");

    // Reset during the third cycle of a burst.
    do_reset();
    set_w(7, 8);
    request = 32'h0000_0080;
    step(1'b1, 7, "burst_c1");
    step(1'b1, 7, "burst_c2");
    step(1'b1, 7, "burst_c3");
    reset = 1'b1;
    step(1'b0, 0, "reset_mid_burst");
    reset = 1'b0;
    step(1'b1, 7, "after_mid_reset");

    // Sole requester is re-granted after its burst expires; idle when none.
    do_reset();
    set_w(3, 2);
    request = 32'h0000_0008;
    for (int i = 0; i < 5; i++) step(1'b1, 3, "sole_regrant");
    request = '0;
    step(1'b0, 0, "no_request");
    step(1'b0, 0, "still_idle");

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
